hz_unit_mc: RTL

Parametrised pipeline hazard unit for the 5-stage RISC-V core, extended for a variable-latency multi-cycle execute unit (MUL/DIV). It provides M/W-to-E operand forwarding, load-use stalls and branch flushes, and adds a registered scoreboard FSM. The FSM tracks the one in-flight multi-cycle result and stalls dependent, write-after-write and structurally conflicting instructions. It sits beside the datapath and drives the F/D/E pipeline-register enables and flushes plus the E-stage forwarding muxes.

---
 rtl/hz_pkg.sv | 21 ++
 rtl/hz_unit_mc_if.sv | 72 +++++++
 rtl/hz_fwd_sel.sv | 36 +++
 rtl/hz_unit_mc.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hz_pkg.sv
// ---------------------------------------------------------------------------
// hz_pkg
// Shared encodings for the hazard unit slice:
//   FWD_RF / FWD_W / FWD_M : E-stage forward mux selects
//   RES_LOAD               : resultsrc encoding that marks a load
//   hz_state_t             : multi-cycle scoreboard states
// ---------------------------------------------------------------------------
package hz_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic {
        HZ_IDLE = 1'b0,
        HZ_BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hz_unit_mc_if.sv
// ---------------------------------------------------------------------------
// hz_unit_mc_if
// Bundle between the datapath and the hazard unit.
//   master : datapath side, drives register addresses / control, receives
//            stall, flush and forward selects
//   slave  : hazard unit side
// Parameters: AW (register address width), CNT_W (perf counter width, only
// present when HZ_PERF_CNT_EN is defined, together with stall_cycles and
// flush_cycles).
// ---------------------------------------------------------------------------
interface hz_unit_mc_if #(
    parameter int AW = 5
`ifdef HZ_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
);
    // D stage
    logic [AW-1:0] rs1d;
    logic [AW-1:0] rs2d;
    logic [AW-1:0] rdd;
    logic          regwrited;
    // E stage
    logic [AW-1:0] rs1e;
    logic [AW-1:0] rs2e;
    logic [AW-1:0] rde;
    logic [1:0]    pcsrce;
    logic [1:0]    resultsrce;
    logic          mc_start_e;
    logic          mc_done;
    // M / W stages
    logic [AW-1:0] rdm;
    logic          regwritem;
    logic [AW-1:0] rdw;
    logic          regwritew;
    // Hazard responses
    logic          stallf;
    logic          stalld;
    logic          stalle;
    logic          flushd;
    logic          flushe;
    logic [1:0]    fwae;
    logic [1:0]    fwbe;
    logic          mc_busy;
    logic          mc_err;
`ifdef HZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;
`endif

    modport master (
        output rs1d, rs2d, rdd, regwrited,
        output rs1e, rs2e, rde, pcsrce, resultsrce, mc_start_e, mc_done,
        output rdm, regwritem, rdw, regwritew,
        input  stallf, stalld, stalle, flushd, flushe, fwae, fwbe,
        input  mc_busy, mc_err
`ifdef HZ_PERF_CNT_EN
        , input stall_cycles, flush_cycles
`endif
    );

    modport slave (
        input  rs1d, rs2d, rdd, regwrited,
        input  rs1e, rs2e, rde, pcsrce, resultsrce, mc_start_e, mc_done,
        input  rdm, regwritem, rdw, regwritew,
        output stallf, stalld, stalle, flushd, flushe, fwae, fwbe,
        output mc_busy, mc_err
`ifdef HZ_PERF_CNT_EN
        , output stall_cycles, flush_cycles
`endif
    );

endinterface

// File: rtl/hz_fwd_sel.sv
// ---------------------------------------------------------------------------
// hz_fwd_sel
// Forward select for one E-stage source operand.
//   rs                 : E-stage source register
//   rdm / regwritem    : M-stage destination and write enable
//   rdw / regwritew    : W-stage destination and write enable
//   sel                : FWD_M, FWD_W or FWD_RF
// The M stage holds the younger result, so it wins over W. x0 never
// forwards because it always reads as zero.
// ---------------------------------------------------------------------------
module hz_fwd_sel
    import hz_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rdm,
    input  logic          regwritem,
    input  logic [AW-1:0] rdw,
    input  logic          regwritew,
    output logic [1:0]    sel
);

    logic rs_nz;
    assign rs_nz = (rs != '0);

    always_comb begin
        sel = FWD_RF;
        if (rs_nz && regwritem && (rs == rdm)) begin
            sel = FWD_M;
        end else if (rs_nz && regwritew && (rs == rdw)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hz_unit_mc.sv
// ---------------------------------------------------------------------------
// hz_unit_mc
// Hazard unit for the 5-stage core with one variable-latency multi-cycle
// execute unit (MUL/DIV).
//   clk, rst   : clock, synchronous active-high reset
//   bus        : hz_unit_mc_if.slave (D/E/M/W register info in, stall /
//                flush / forward selects and scoreboard status out)
// Parameters:
//   AW         : register address width
//   MC_MAX_LAT : watchdog limit on busy cycles (>= 2)
//   CNT_W      : perf counter width (only with HZ_PERF_CNT_EN)
// Optional feature: define HZ_PERF_CNT_EN to add the saturating
// stall_cycles / flush_cycles counters.
//
// All stall, flush and forward outputs are combinational from the inputs
// and the registered scoreboard; every output is held at zero while rst
// is high.
// ---------------------------------------------------------------------------
module hz_unit_mc
    import hz_pkg::*;
#(
    parameter int AW         = 5,
    parameter int MC_MAX_LAT = 64
`ifdef HZ_PERF_CNT_EN
    , parameter int CNT_W    = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    hz_unit_mc_if.slave bus
);

    localparam int CW = $clog2(MC_MAX_LAT);

    // -----------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------
    hz_state_t     state_reg;
    logic [AW-1:0] mc_rd_reg;
    logic [CW-1:0] busy_cnt_reg;
    logic          mc_err_reg;

    logic busy;
    logic wd_hit;
    assign busy   = (state_reg == HZ_BUSY);
    assign wd_hit = busy && !bus.mc_done && (busy_cnt_reg == CW'(MC_MAX_LAT - 1));

    // -----------------------------------------------------------------
    // Forwarding, one selector per E operand
    // -----------------------------------------------------------------
    logic [AW-1:0] rs_e    [2];
    logic [1:0]    fwd_sel [2];

    assign rs_e[0] = bus.rs1e;
    assign rs_e[1] = bus.rs2e;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            hz_fwd_sel #(
                .AW (AW)
            ) u_fwd_sel (
                .rs        (rs_e[gi]),
                .rdm       (bus.rdm),
                .regwritem (bus.regwritem),
                .rdw       (bus.rdw),
                .regwritew (bus.regwritew),
                .sel       (fwd_sel[gi])
            );
        end
    endgenerate

    // -----------------------------------------------------------------
    // Stall / flush decisions
    // -----------------------------------------------------------------
    logic rde_nz;
    logic d_reads_rde;
    logic load_use;
    logic mc_launch;
    logic mc_use;
    logic d_reads_mc;
    logic busy_dep;
    logic struct_stall;
    logic dep_stall;
    logic branch;

    assign rde_nz      = (bus.rde != '0);
    assign d_reads_rde = (bus.rs1d == bus.rde) || (bus.rs2d == bus.rde);

    assign load_use    = (bus.resultsrce == RES_LOAD) && rde_nz && d_reads_rde;

    // An MC op only launches when the unit is free or frees up this edge;
    // otherwise it is held in E by the structural stall and checked again.
    assign mc_launch   = bus.mc_start_e && (!busy || bus.mc_done);
    assign mc_use      = mc_launch && rde_nz && d_reads_rde;

    // RAW and WAW against the in-flight result. Still active in the done
    // cycle: the regfile only holds the value from the next cycle on.
    assign d_reads_mc  = (bus.rs1d == mc_rd_reg) || (bus.rs2d == mc_rd_reg) ||
                         (bus.regwrited && (bus.rdd == mc_rd_reg));
    assign busy_dep    = busy && (mc_rd_reg != '0) && d_reads_mc;

    assign struct_stall = busy && bus.mc_start_e && !bus.mc_done;
    assign dep_stall    = load_use || mc_use || busy_dep;
    assign branch       = |bus.pcsrce;

    logic stalld_w;
    logic flushe_w;

    // A taken branch discards the younger F/D work, so it cancels F/D
    // holds. The E hold stays: the older MC op in E must not be lost.
    // A structurally held E op must not be bubbled by a dependency stall.
    assign stalld_w = !rst && !branch && (dep_stall || struct_stall);
    assign flushe_w = !rst && (branch || (dep_stall && !struct_stall));

    assign bus.stallf  = stalld_w;
    assign bus.stalld  = stalld_w;
    assign bus.stalle  = !rst && struct_stall;
    assign bus.flushd  = !rst && branch;
    assign bus.flushe  = flushe_w;
    assign bus.fwae    = rst ? FWD_RF : fwd_sel[0];
    assign bus.fwbe    = rst ? FWD_RF : fwd_sel[1];
    assign bus.mc_busy = !rst && busy;
    assign bus.mc_err  = !rst && mc_err_reg;

    // -----------------------------------------------------------------
    // Scoreboard FSM
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= HZ_IDLE;
            mc_rd_reg    <= '0;
            busy_cnt_reg <= '0;
            mc_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                HZ_IDLE: begin
                    // rd==0 still occupies the unit, so BUSY is entered
                    if (bus.mc_start_e) begin
                        state_reg    <= HZ_BUSY;
                        mc_rd_reg    <= bus.rde;
                        busy_cnt_reg <= '0;
                    end
                end
                HZ_BUSY: begin
                    if (bus.mc_done) begin
                        if (bus.mc_start_e) begin
                            // back-to-back: next op takes over the unit
                            mc_rd_reg    <= bus.rde;
                            busy_cnt_reg <= '0;
                        end else begin
                            state_reg    <= HZ_IDLE;
                        end
                    end else if (wd_hit) begin
                        // unit never answered: give up on the op and
                        // flag it so software can find out
                        state_reg    <= HZ_IDLE;
                        mc_err_reg   <= 1'b1;
                    end else begin
                        busy_cnt_reg <= busy_cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= HZ_IDLE;
                end
            endcase
        end
    end

`ifdef HZ_PERF_CNT_EN
    // -----------------------------------------------------------------
    // Saturating performance counters
    // -----------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stalld_w && !(&stall_cnt_reg)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (flushe_w && !(&flush_cnt_reg)) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cycles = rst ? '0 : stall_cnt_reg;
    assign bus.flush_cycles = rst ? '0 : flush_cnt_reg;
`endif

endmodule
